// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lsu_pkg
// Description : Shared types, funct3 encodings and the byte-mask helper for
//               the load/store unit.
// Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2,
        RESP  = 2'd3
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    function automatic logic [7:0] size_mask(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   size_mask = 8'h01;
            2'b01:   size_mask = 8'h03;
            2'b10:   size_mask = 8'h0F;
            default: size_mask = 8'hFF;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_load_align.sv
`default_nettype none
// ============================================================================
// Module      : lsu_load_align
// Description : Extracts the addressed bytes from up to two read beats and
//               sign/zero-extends them to XLEN according to funct3.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_load_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2*XLEN-1:0]            data,
    input  logic [$clog2(XLEN/8)-1:0]    offset,
    input  logic [2:0]                   funct3,
    output logic [XLEN-1:0]              result
);

    localparam int IW = $clog2(2 * XLEN);

    logic [2*XLEN-1:0] w_shifted;
    logic [IW-1:0]     w_top;
    logic              w_sign;
    int                w_nbits;

    assign w_shifted = data >> {offset, 3'b000};

    // funct3[2] selects zero extension; funct3[1:0] is log2 of the byte count
    always_comb begin
        w_nbits = 8 << funct3[1:0];
        w_top   = IW'(w_nbits - 1);
        w_sign  = ~funct3[2] & w_shifted[w_top];
        result  = '0;
        for (int i = 0; i < XLEN; i++) begin
            result[i] = (i < w_nbits) ? w_shifted[i] : w_sign;
        end
    end

endmodule
`default_nettype wire

// File: rtl/lsu_pipelined.sv
`default_nettype none
// ============================================================================
// Module      : lsu_pipelined
// Description : Multi-cycle load/store unit for the pipelined core memory
//               stage. Optional macro LSU_MISALIGN_SPLIT_EN splits misaligned
//               accesses into one or two bus beats instead of faulting them.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_pipelined
    import lsu_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [2:0]           req_funct3,
    input  logic [ADDR_W-1:0]    req_addr,
    input  logic [XLEN-1:0]      req_wdata,
    input  logic [4:0]           req_rd,
    output logic                 resp_valid,
    output logic [XLEN-1:0]      resp_data,
    output logic [4:0]           resp_rd,
    output logic                 resp_fault,
    output logic [ADDR_W-1:0]    address,
    output logic [XLEN-1:0]      write_data,
    output logic                 write_enable,
    output logic [XLEN/8-1:0]    write_mask,
    output logic                 read_enable,
    input  logic [XLEN-1:0]      read_data,
    input  logic                 read_valid
);

    localparam int NB    = XLEN / 8;
    localparam int OFF_W = $clog2(NB);
`ifdef LSU_MISALIGN_SPLIT_EN
    localparam logic SPLIT_EN = 1'b1;
`else
    localparam logic SPLIT_EN = 1'b0;
`endif

    lsu_state_t          r_state, w_state_nxt;
    logic                r_write;
    logic [2:0]          r_funct3;
    logic [ADDR_W-1:0]   r_addr;
    logic [XLEN-1:0]     r_wdata;
    logic [4:0]          r_rd;
    logic                r_fault;
    logic [XLEN-1:0]     r_rdata0, r_rdata1;

    logic                w_accept, w_req_illegal, w_req_misalign, w_req_fault;
    logic                w_beat_done, w_cross;
    logic [2:0]          w_align;
    logic [OFF_W-1:0]    w_off;
    logic [2*NB-1:0]     w_mask2;
    logic [2*XLEN-1:0]   w_wdata2;
    logic [ADDR_W-1:0]   w_base;
    logic [XLEN-1:0]     w_load;

    assign w_accept       = (r_state == IDLE) && req_valid;
    assign w_align        = 3'((4'b0001 << req_funct3[1:0]) - 4'b0001);
    assign w_req_misalign = |(req_addr[2:0] & w_align);
    assign w_req_illegal  = (req_funct3 == 3'b111) ||
                            ((XLEN == 32) && (req_funct3 == F3_D || req_funct3 == F3_WU));
    assign w_req_fault    = w_req_illegal || (w_req_misalign && !SPLIT_EN);

    // Double-width mask/data: low half is beat 0, high half spills into beat 1
    assign w_off       = r_addr[OFF_W-1:0];
    assign w_mask2     = (2*NB)'(size_mask(r_funct3)) << w_off;
    assign w_wdata2    = {{XLEN{1'b0}}, r_wdata} << {w_off, 3'b000};
    assign w_base      = r_addr & ~ADDR_W'(NB - 1);
    assign w_cross     = SPLIT_EN && (|w_mask2[2*NB-1:NB]);
    assign w_beat_done = r_write || read_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_write  <= 1'b0;
            r_funct3 <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rd     <= '0;
            r_fault  <= 1'b0;
            r_rdata0 <= '0;
            r_rdata1 <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_write  <= req_write;
                r_funct3 <= req_funct3;
                r_addr   <= req_addr;
                r_wdata  <= req_wdata;
                r_rd     <= req_rd;
                r_fault  <= w_req_fault;
                r_rdata0 <= '0;
                r_rdata1 <= '0;
            end
            if (r_state == BEAT0 && !r_write && read_valid) begin
                r_rdata0 <= read_data;
            end
            if (r_state == BEAT1 && !r_write && read_valid) begin
                r_rdata1 <= read_data;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (req_valid)   w_state_nxt = w_req_fault ? RESP : BEAT0;
            BEAT0:   if (w_beat_done) w_state_nxt = w_cross ? BEAT1 : RESP;
            BEAT1:   if (w_beat_done) w_state_nxt = RESP;
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready    = (r_state == IDLE);
        address      = '0;
        write_data   = '0;
        write_enable = 1'b0;
        write_mask   = '0;
        read_enable  = 1'b0;
        resp_valid   = 1'b0;
        resp_data    = '0;
        resp_rd      = '0;
        resp_fault   = 1'b0;
        case (r_state)
            BEAT0: begin
                address      = w_base;
                write_mask   = w_mask2[NB-1:0];
                write_enable = r_write;
                read_enable  = !r_write;
                if (r_write) write_data = w_wdata2[XLEN-1:0];
            end
            BEAT1: begin
                address      = w_base + ADDR_W'(NB);
                write_mask   = w_mask2[2*NB-1:NB];
                write_enable = r_write;
                read_enable  = !r_write;
                if (r_write) write_data = w_wdata2[2*XLEN-1:XLEN];
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_fault = r_fault;
                if (!r_write) begin
                    resp_rd = r_rd;
                    if (!r_fault) resp_data = w_load;
                end
            end
            default: ;
        endcase
    end

    lsu_load_align #(
        .XLEN (XLEN)
    ) u_load_align (
        .data   ({r_rdata1, r_rdata0}),
        .offset (w_off),
        .funct3 (r_funct3),
        .result (w_load)
    );

endmodule
`default_nettype wire

// File: tb/tb_lsu_pipelined.sv
`default_nettype none
// ============================================================================
// Module      : tb_lsu_pipelined
// Description : Directed self-checking bench for lsu_pipelined, XLEN 32 and 64.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu_pipelined;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          n_checks = 0;
    int          n_errors = 0;

    // XLEN = 32 instance
    logic        req_valid = 0, req_write = 0;
    logic [2:0]  req_funct3 = '0;
    logic [31:0] req_addr = '0, req_wdata = '0, read_data = '0;
    logic [4:0]  req_rd = '0;
    logic        read_valid = 0;
    logic        req_ready, resp_valid, resp_fault, write_enable, read_enable;
    logic [31:0] resp_data, address, write_data;
    logic [4:0]  resp_rd;
    logic [3:0]  write_mask;

    // XLEN = 64 instance
    logic        x_req_valid = 0, x_req_write = 0;
    logic [2:0]  x_req_funct3 = '0;
    logic [31:0] x_req_addr = '0;
    logic [63:0] x_req_wdata = '0, x_read_data = '0;
    logic [4:0]  x_req_rd = '0;
    logic        x_read_valid = 0;
    logic        x_req_ready, x_resp_valid, x_resp_fault, x_write_enable, x_read_enable;
    logic [63:0] x_resp_data, x_write_data;
    logic [31:0] x_address;
    logic [4:0]  x_resp_rd;
    logic [7:0]  x_write_mask;

    always #5 clk = ~clk;

    lsu_pipelined #(.XLEN(32), .ADDR_W(32)) u_dut32 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_rd(resp_rd), .resp_fault(resp_fault),
        .address(address), .write_data(write_data), .write_enable(write_enable),
        .write_mask(write_mask), .read_enable(read_enable),
        .read_data(read_data), .read_valid(read_valid)
    );

    lsu_pipelined #(.XLEN(64), .ADDR_W(32)) u_dut64 (
        .clk(clk), .rst(rst),
        .req_valid(x_req_valid), .req_ready(x_req_ready), .req_write(x_req_write),
        .req_funct3(x_req_funct3), .req_addr(x_req_addr), .req_wdata(x_req_wdata), .req_rd(x_req_rd),
        .resp_valid(x_resp_valid), .resp_data(x_resp_data), .resp_rd(x_resp_rd), .resp_fault(x_resp_fault),
        .address(x_address), .write_data(x_write_data), .write_enable(x_write_enable),
        .write_mask(x_write_mask), .read_enable(x_read_enable),
        .read_data(x_read_data), .read_valid(x_read_valid)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Present a request on the 32-bit unit at a negedge; it is taken at the next posedge.
    task automatic send32(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [4:0] rd);
        req_valid  = 1'b1;
        req_write  = wr;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        req_rd     = rd;
        check("hs_ready", {63'd0, req_ready}, 64'd1);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    initial begin
        int n_hs, n_wr, n_resp, idx;
        logic adv;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", {63'd0, req_ready}, 64'd1);
        check("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
        check("rst_addr", {32'd0, address}, 64'd0);
        check("rst_enables", {62'd0, write_enable, read_enable}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // SB 0x103
        send32(1'b1, 3'b000, 32'h103, 32'h0000_00AB, 5'd0);
        check("sb_addr", {32'd0, address}, 64'h100);
        check("sb_mask", {60'd0, write_mask}, 64'h8);
        check("sb_wdata", {32'd0, write_data}, 64'hAB00_0000);
        check("sb_we", {63'd0, write_enable}, 64'd1);
        check("sb_busy", {63'd0, req_ready}, 64'd0);
        @(negedge clk);
        check("sb_resp", {63'd0, resp_valid}, 64'd1);
        check("sb_resp_data", {32'd0, resp_data}, 64'd0);
        check("sb_we_off", {63'd0, write_enable}, 64'd0);
        @(negedge clk);
        check("sb_idle", {62'd0, req_ready, resp_valid}, 64'b10);

        // LH 0x202 with three wait cycles
        send32(1'b0, 3'b001, 32'h202, 32'h0, 5'd7);
        check("lh_addr", {32'd0, address}, 64'h200);
        for (int i = 0; i < 3; i++) begin
            check("lh_re_wait", {62'd0, read_enable, resp_valid}, 64'b10);
            @(negedge clk);
        end
        read_valid = 1'b1;
        read_data  = 32'h8001_0000;
        check("lh_re_last", {63'd0, read_enable}, 64'd1);
        @(negedge clk);
        read_valid = 1'b0;
        check("lh_resp", {63'd0, resp_valid}, 64'd1);
        check("lh_data", {32'd0, resp_data}, 64'hFFFF_8001);
        check("lh_rd", {59'd0, resp_rd}, 64'd7);
        @(negedge clk);

        // LD on XLEN=32 is illegal
        send32(1'b0, 3'b011, 32'h0, 32'h0, 5'd4);
        check("ld32_fault", {61'd0, resp_valid, resp_fault, read_enable}, 64'b110);
        @(negedge clk);

        // LW 0x102 misaligned
        send32(1'b0, 3'b010, 32'h102, 32'h0, 5'd5);
`ifdef LSU_MISALIGN_SPLIT_EN
        check("lwm_b0_addr", {32'd0, address}, 64'h100);
        check("lwm_b0_mask", {60'd0, write_mask}, 64'hC);
        read_valid = 1'b1;
        read_data  = 32'h4433_2211;
        @(negedge clk);
        check("lwm_b1_addr", {32'd0, address}, 64'h104);
        check("lwm_b1_mask", {60'd0, write_mask}, 64'h3);
        check("lwm_b1_re", {63'd0, read_enable}, 64'd1);
        read_data = 32'h8877_6655;
        @(negedge clk);
        read_valid = 1'b0;
        check("lwm_resp", {62'd0, resp_valid, resp_fault}, 64'b10);
        check("lwm_data", {32'd0, resp_data}, 64'h6655_4433);
`else
        check("lwm_fault", {61'd0, resp_valid, resp_fault, read_enable}, 64'b110);
        check("lwm_no_we", {63'd0, write_enable}, 64'd0);
`endif
        @(negedge clk);

        // Reset during a load wait, then a stray read_valid
        send32(1'b0, 3'b010, 32'h300, 32'h0, 5'd3);
        check("rw_re", {63'd0, read_enable}, 64'd1);
        rst = 1'b1;
        #1;
        check("rw_outputs", {30'd0, address, read_enable, resp_valid}, 64'd0);
        check("rw_ready", {63'd0, req_ready}, 64'd1);
        @(negedge clk);
        rst        = 1'b0;
        read_valid = 1'b1;
        read_data  = 32'hDEAD_BEEF;
        @(negedge clk);
        read_valid = 1'b0;
        check("rw_no_resp", {62'd0, resp_valid, req_ready}, 64'b01);
        @(negedge clk);
        check("rw_no_resp2", {62'd0, resp_valid, req_ready}, 64'b01);

        // Back-to-back stores with req_valid held
        n_hs = 0; n_wr = 0; n_resp = 0; idx = 0; adv = 1'b0;
        req_valid  = 1'b1;
        req_write  = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 32'h10;
        req_wdata  = 32'hC0DE_0000;
        for (int cyc = 0; cyc < 30 && n_resp < 3; cyc++) begin
            if (adv) begin
                adv = 1'b0;
                idx++;
                if (idx < 3) begin
                    req_addr  = 32'h10 + 32'(4 * idx);
                    req_wdata = 32'hC0DE_0000 | 32'(idx);
                end else begin
                    req_valid = 1'b0;
                end
            end
            if (write_enable) begin
                check("b2b_addr", {32'd0, address}, 64'(32'h10 + 32'(4 * n_wr)));
                check("b2b_data", {32'd0, write_data}, 64'(32'hC0DE_0000 | 32'(n_wr)));
                n_wr++;
            end
            if (resp_valid) n_resp++;
            if (req_valid && req_ready) begin
                n_hs++;
                adv = 1'b1;
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        check("b2b_handshakes", 64'(n_hs), 64'd3);
        check("b2b_writes", 64'(n_wr), 64'd3);
        check("b2b_resps", 64'(n_resp), 64'd3);
        @(negedge clk);

        // XLEN=64: LWU 0x4
        x_req_valid = 1'b1; x_req_write = 1'b0; x_req_funct3 = 3'b110;
        x_req_addr = 32'h4; x_req_rd = 5'd9;
        check("x_ready", {63'd0, x_req_ready}, 64'd1);
        @(negedge clk);
        x_req_valid = 1'b0;
        check("x_lwu_addr", {32'd0, x_address}, 64'h0);
        check("x_lwu_mask", {56'd0, x_write_mask}, 64'hF0);
        x_read_valid = 1'b1;
        x_read_data  = 64'hF000_0000_0000_0000;
        @(negedge clk);
        x_read_valid = 1'b0;
        check("x_lwu_data", x_resp_data, 64'h0000_0000_F000_0000);
        check("x_lwu_rd", {58'd0, x_resp_fault, x_resp_rd}, 64'd9);
        @(negedge clk);

        // XLEN=64: LD 0x8
        x_req_valid = 1'b1; x_req_funct3 = 3'b011; x_req_addr = 32'h8; x_req_rd = 5'd2;
        @(negedge clk);
        x_req_valid = 1'b0;
        check("x_ld_addr", {32'd0, x_address}, 64'h8);
        x_read_valid = 1'b1;
        x_read_data  = 64'h8000_0000_0000_0001;
        @(negedge clk);
        x_read_valid = 1'b0;
        check("x_ld_data", x_resp_data, 64'h8000_0000_0000_0001);
        check("x_ld_valid", {62'd0, x_resp_valid, x_resp_fault}, 64'b10);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
